// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the instruction loader, data access and
// instruction fetch. One access is in flight at a time; read data returns via registers.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1   // issue-to-MemRdata latency, 1..4
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          LoadInstructions,
  input  logic [AW-1:0] LoadAddress,
  input  logic [DW-1:0] LoadData,
  output logic          LoadBusy,
  input  logic          IfReq,
  input  logic [AW-1:0] IfAddr,
  output logic [DW-1:0] IfRdata,
  output logic          IfValid,
  output logic          IfStall,
  input  logic          DmRead,
  input  logic          DmWrite,
  input  logic [AW-1:0] DmAddr,
  input  logic [DW-1:0] DmWdata,
  output logic [DW-1:0] DmRdata,
  output logic          DmValid,
  output logic          DmStall,
  output logic          MemRead,
  output logic          MemWrite,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWdata,
  input  logic [DW-1:0] MemRdata
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;

  state_t        state, state_nxt;
  owner_t        owner, owner_nxt;
  logic [1:0]    count, count_nxt;
  logic          if_capture, dm_capture;
  logic [DW-1:0] if_rdata, dm_rdata;

  always_comb begin
    // NOTE: every signal written here gets its default first, so no path can infer a latch.
    state_nxt  = state;
    owner_nxt  = owner;
    count_nxt  = count;
    if_capture = 1'b0;
    dm_capture = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemAddr    = '0;
    MemWdata   = '0;
    case (state)
      S_IDLE: begin
        // Strobes are suppressed while reset is asserted so every output reads 0.
        if (Reset) begin
          if (LoadInstructions) begin
            MemWrite = 1'b1;
            MemAddr  = LoadAddress;
            MemWdata = LoadData;
          end else if (DmWrite) begin
            MemWrite  = 1'b1;
            MemAddr   = DmAddr;
            MemWdata  = DmWdata;
            owner_nxt = OWN_DM;
            state_nxt = S_DONE;
          end else if (DmRead) begin
            MemRead   = 1'b1;
            MemAddr   = DmAddr;
            owner_nxt = OWN_DM;
            count_nxt = 2'(MEM_LAT - 1);
            state_nxt = S_WAIT;
          end else if (IfReq) begin
            MemRead   = 1'b1;
            MemAddr   = IfAddr;
            owner_nxt = OWN_IF;
            count_nxt = 2'(MEM_LAT - 1);
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (count == 2'd0) begin
          if_capture = (owner == OWN_IF);
          dm_capture = (owner == OWN_DM);
          state_nxt  = S_DONE;
        end else begin
          count_nxt = count - 2'd1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state <= S_IDLE;
      owner <= OWN_IF;
      count <= 2'd0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      count <= count_nxt;
    end
  end

  // NOTE: the read-data registers are reset because they drive outputs that must read 0 after reset.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      if (if_capture) if_rdata <= MemRdata;
      if (dm_capture) dm_rdata <= MemRdata;
    end
  end

  assign IfRdata  = if_rdata;
  assign DmRdata  = dm_rdata;
  assign IfValid  = (state == S_DONE) && (owner == OWN_IF);
  assign DmValid  = (state == S_DONE) && (owner == OWN_DM);
  assign IfStall  = Reset && IfReq && !IfValid;
  assign DmStall  = Reset && (DmRead || DmWrite) && !DmValid;
  assign LoadBusy = LoadInstructions && (state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT 1 and 3) with memory models, a
// transaction-level reference model checked every cycle, directed sequences and a priority table.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        load;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_read;
    logic        dm_write;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
  } req_t;

  typedef struct packed {
    logic        load;
    logic        dm_write;
    logic        dm_read;
    logic        if_req;
    logic        exp_mr;
    logic        exp_mw;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
  } vec_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  req_t        rq [2];
  logic        load_busy [2], if_valid [2], if_stall [2], dm_valid [2], dm_stall [2];
  logic        mem_read [2], mem_write [2];
  logic [31:0] if_rdata [2], dm_rdata [2], mem_addr [2], mem_wdata [2], mem_rdata [2];
  logic [31:0] mem  [2][64];
  logic [31:0] pipe [2][4];

  int compared   = 0;
  int mismatched = 0;

  // Reference model state, per instance: cycle arithmetic over outstanding accesses.
  int          ncyc = 0;
  int          free_at [2];
  int          valid_at [2];
  bit          own_dm [2];
  bit          pend_rd [2];
  logic [31:0] pend [2];
  logic [31:0] e_if_rd [2];
  logic [31:0] e_dm_rd [2];
  logic [31:0] sh [2][64];

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_dut_lat1 (
    .clk(clk), .Reset(rst_n),
    .LoadInstructions(rq[0].load), .LoadAddress(rq[0].load_addr), .LoadData(rq[0].load_data),
    .LoadBusy(load_busy[0]),
    .IfReq(rq[0].if_req), .IfAddr(rq[0].if_addr), .IfRdata(if_rdata[0]),
    .IfValid(if_valid[0]), .IfStall(if_stall[0]),
    .DmRead(rq[0].dm_read), .DmWrite(rq[0].dm_write), .DmAddr(rq[0].dm_addr),
    .DmWdata(rq[0].dm_wdata), .DmRdata(dm_rdata[0]), .DmValid(dm_valid[0]), .DmStall(dm_stall[0]),
    .MemRead(mem_read[0]), .MemWrite(mem_write[0]), .MemAddr(mem_addr[0]),
    .MemWdata(mem_wdata[0]), .MemRdata(mem_rdata[0])
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) u_dut_lat3 (
    .clk(clk), .Reset(rst_n),
    .LoadInstructions(rq[1].load), .LoadAddress(rq[1].load_addr), .LoadData(rq[1].load_data),
    .LoadBusy(load_busy[1]),
    .IfReq(rq[1].if_req), .IfAddr(rq[1].if_addr), .IfRdata(if_rdata[1]),
    .IfValid(if_valid[1]), .IfStall(if_stall[1]),
    .DmRead(rq[1].dm_read), .DmWrite(rq[1].dm_write), .DmAddr(rq[1].dm_addr),
    .DmWdata(rq[1].dm_wdata), .DmRdata(dm_rdata[1]), .DmValid(dm_valid[1]), .DmStall(dm_stall[1]),
    .MemRead(mem_read[1]), .MemWrite(mem_write[1]), .MemAddr(mem_addr[1]),
    .MemWdata(mem_wdata[1]), .MemRdata(mem_rdata[1])
  );

  // Memory models: registered read, then extra pipeline stages; junk when no read was issued.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_write[d]) mem[d][mem_addr[d][5:0]] <= mem_wdata[d];
      pipe[d][0] <= mem_read[d] ? mem[d][mem_addr[d][5:0]] : 32'hBAD0_BAD0;
      for (int k = 1; k < 4; k++) pipe[d][k] <= pipe[d][k-1];
    end
  end
  assign mem_rdata[0] = pipe[0][0];
  assign mem_rdata[1] = pipe[1][2];

  function automatic logic [31:0] word(input int i);
    return (i == 4) ? 32'h8C01_0000 : (32'hA500_0000 | (32'(i) * 32'h0001_0203));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, ncyc, act, exp);
    end
  endtask

  task automatic model_check(input int d);
    req_t        r;
    int          lat;
    bit          idle, eiv, edv, emr, emw;
    logic [31:0] ea, ew;
    string       p;
    r   = rq[d];
    lat = (d == 0) ? 1 : 3;
    p   = $sformatf("lat%0d.", lat);
    if (!rst_n) begin
      free_at[d]  = ncyc + 1;
      valid_at[d] = -10;
      e_if_rd[d]  = '0;
      e_dm_rd[d]  = '0;
      check({p, "rst_outputs"},
            {load_busy[d], if_valid[d], if_stall[d], dm_valid[d], dm_stall[d], mem_read[d], mem_write[d]}, '0);
      check({p, "rst_mem_addr_wdata"}, {mem_addr[d], mem_wdata[d]}, '0);
      check({p, "rst_rdata"}, {if_rdata[d], dm_rdata[d]}, '0);
      return;
    end
    eiv = (valid_at[d] == ncyc) && !own_dm[d];
    edv = (valid_at[d] == ncyc) && own_dm[d];
    if ((valid_at[d] == ncyc) && pend_rd[d]) begin
      if (own_dm[d]) e_dm_rd[d] = pend[d];
      else           e_if_rd[d] = pend[d];
    end
    idle = (ncyc >= free_at[d]);
    emr = 1'b0; emw = 1'b0; ea = '0; ew = '0;
    if (idle) begin
      if (r.load) begin
        emw = 1'b1; ea = r.load_addr; ew = r.load_data;
        sh[d][ea[5:0]] = ew;
      end else if (r.dm_write) begin
        emw = 1'b1; ea = r.dm_addr; ew = r.dm_wdata;
        sh[d][ea[5:0]] = ew;
        own_dm[d] = 1'b1; pend_rd[d] = 1'b0;
        valid_at[d] = ncyc + 1; free_at[d] = ncyc + 2;
      end else if (r.dm_read) begin
        emr = 1'b1; ea = r.dm_addr; pend[d] = sh[d][ea[5:0]];
        own_dm[d] = 1'b1; pend_rd[d] = 1'b1;
        valid_at[d] = ncyc + lat + 1; free_at[d] = ncyc + lat + 2;
      end else if (r.if_req) begin
        emr = 1'b1; ea = r.if_addr; pend[d] = sh[d][ea[5:0]];
        own_dm[d] = 1'b0; pend_rd[d] = 1'b1;
        valid_at[d] = ncyc + lat + 1; free_at[d] = ncyc + lat + 2;
      end
    end
    check({p, "load_busy"}, load_busy[d], r.load && !idle);
    check({p, "if_valid"},  if_valid[d], eiv);
    check({p, "dm_valid"},  dm_valid[d], edv);
    check({p, "if_stall"},  if_stall[d], r.if_req && !eiv);
    check({p, "dm_stall"},  dm_stall[d], (r.dm_read || r.dm_write) && !edv);
    check({p, "strobes"},   {mem_read[d], mem_write[d]}, {emr, emw});
    if (emr || emw) check({p, "mem_addr"}, mem_addr[d], ea);
    if (emw)        check({p, "mem_wdata"}, mem_wdata[d], ew);
    check({p, "if_rdata"},  if_rdata[d], e_if_rd[d]);
    check({p, "dm_rdata"},  dm_rdata[d], e_dm_rd[d]);
  endtask

  task automatic eval();
    @(negedge clk);
    model_check(0);
    model_check(1);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  task automatic idle_cycles(input int n);
    rq[0] = '0;
    rq[1] = '0;
    repeat (n) begin eval(); adv(); end
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.load      = ($urandom_range(7) == 0);
    r.load_addr = $urandom_range(63);
    r.load_data = $urandom();
    r.if_req    = 1'($urandom_range(1));
    r.if_addr   = $urandom_range(63);
    r.dm_read   = ($urandom_range(2) == 0);
    r.dm_write  = ($urandom_range(3) == 0);
    r.dm_addr   = $urandom_range(63);
    r.dm_wdata  = $urandom();
    return r;
  endfunction

  vec_t vecs [6];

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'd40, 32'h1111_0040};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'd44, 32'h2222_0044};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd44, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd48, 32'h0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,  32'h0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd44, 32'h2222_0044};
    for (int d = 0; d < 2; d++) begin
      free_at[d] = 0; valid_at[d] = -10; own_dm[d] = 1'b0; pend_rd[d] = 1'b0;
      pend[d] = '0; e_if_rd[d] = '0; e_dm_rd[d] = '0;
    end
    rq[0] = '0;
    rq[1] = '0;

    // Reset state.
    eval();
    check("reset_if_rdata", if_rdata[0], 32'h0);
    adv();
    rst_n = 1'b1;

    // Loader fills both memories; first 8 writes observed with IfReq pending.
    for (int i = 0; i < 64; i++) begin
      for (int d = 0; d < 2; d++) begin
        rq[d].load = 1'b1; rq[d].load_addr = 32'(i); rq[d].load_data = word(i);
      end
      rq[0].if_req  = (i < 8);
      rq[0].if_addr = 32'd0;
      eval();
      if (i < 8) begin
        check("load_mem_write", mem_write[0], 1'b1);
        check("load_addr", mem_addr[0], 32'(i));
        check("load_busy_low", load_busy[0], 1'b0);
        check("load_if_stall", if_stall[0], 1'b1);
      end
      adv();
    end
    idle_cycles(2);

    // Fetch at MEM_LAT=1: valid two cycles after issue.
    rq[0].if_req = 1'b1; rq[0].if_addr = 32'd4;
    eval();
    check("fetch_issue", {mem_read[0], mem_addr[0]}, {1'b1, 32'd4});
    check("fetch_stall_t", if_stall[0], 1'b1);
    adv(); eval();
    check("fetch_stall_t1", {if_stall[0], if_valid[0]}, 2'b10);
    adv(); eval();
    check("fetch_valid", {if_valid[0], if_stall[0]}, 2'b10);
    check("fetch_rdata", if_rdata[0], 32'h8C01_0000);
    adv();
    idle_cycles(1);

    // DM read wins over a simultaneous fetch; fetch follows after the DONE gap.
    rq[0].if_req = 1'b1; rq[0].if_addr = 32'd4; rq[0].dm_read = 1'b1; rq[0].dm_addr = 32'd8;
    eval();
    check("prio_dm_issue", {mem_read[0], mem_addr[0]}, {1'b1, 32'd8});
    adv(); eval(); adv(); eval();
    check("prio_dm_valid", {dm_valid[0], if_valid[0]}, 2'b10);
    check("prio_dm_rdata", dm_rdata[0], word(8));
    adv();
    rq[0].dm_read = 1'b0;
    eval();
    check("prio_if_issue", {mem_read[0], mem_addr[0]}, {1'b1, 32'd4});
    adv(); eval(); adv(); eval();
    check("prio_if_valid", if_valid[0], 1'b1);
    adv();
    idle_cycles(1);

    // DM write then read-back.
    rq[0].dm_write = 1'b1; rq[0].dm_addr = 32'd12; rq[0].dm_wdata = 32'hDEAD_BEEF;
    eval();
    check("wr_issue", {mem_write[0], mem_wdata[0]}, {1'b1, 32'hDEAD_BEEF});
    adv(); eval();
    check("wr_valid", dm_valid[0], 1'b1);
    adv();
    rq[0].dm_write = 1'b0; rq[0].dm_read = 1'b1;
    eval(); adv(); eval(); adv(); eval();
    check("rd_back_valid", dm_valid[0], 1'b1);
    check("rd_back_data", dm_rdata[0], 32'hDEAD_BEEF);
    adv();
    idle_cycles(1);

    // Priority table: one IDLE cycle of stimulus, then drain.
    for (int v = 0; v < 6; v++) begin
      rq[0].load = vecs[v].load; rq[0].load_addr = 32'd40; rq[0].load_data = 32'h1111_0040;
      rq[0].dm_write = vecs[v].dm_write; rq[0].dm_read = vecs[v].dm_read;
      rq[0].dm_addr = 32'd44; rq[0].dm_wdata = 32'h2222_0044;
      rq[0].if_req = vecs[v].if_req; rq[0].if_addr = 32'd48;
      eval();
      check($sformatf("tbl%0d_strobes", v), {mem_read[0], mem_write[0]}, {vecs[v].exp_mr, vecs[v].exp_mw});
      if (vecs[v].exp_mr || vecs[v].exp_mw)
        check($sformatf("tbl%0d_addr", v), mem_addr[0], vecs[v].exp_addr);
      if (vecs[v].exp_mw)
        check($sformatf("tbl%0d_wdata", v), mem_wdata[0], vecs[v].exp_wdata);
      adv();
      idle_cycles(4);
    end

    // MEM_LAT=3: loader arrives mid-fetch and is held off until the fetch is done.
    rq[1].if_req = 1'b1; rq[1].if_addr = 32'd4;
    eval(); adv();
    rq[1].load = 1'b1; rq[1].load_addr = 32'd20; rq[1].load_data = 32'h5A5A_0020;
    for (int k = 1; k <= 4; k++) begin
      eval();
      check($sformatf("lat3_busy_t%0d", k), {load_busy[1], mem_write[1]}, 2'b10);
      if (k == 4) check("lat3_if_valid", {if_valid[1], if_rdata[1]}, {1'b1, 32'h8C01_0000});
      adv();
    end
    rq[1].if_req = 1'b0;
    eval();
    check("lat3_load_issue", {mem_write[1], load_busy[1], mem_addr[1]}, {2'b10, 32'd20});
    adv();
    idle_cycles(2);

    // Reset in the middle of WAIT discards the access.
    rq[0].if_req = 1'b1; rq[0].if_addr = 32'd8;
    eval(); adv();
    rq[0].if_req = 1'b0;
    #2 rst_n = 1'b0;
    eval();
    check("rst_mid_if_rdata", if_rdata[0], 32'h0);
    check("rst_mid_dm_rdata", dm_rdata[0], 32'h0);
    adv(); eval(); adv();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      eval();
      check("rst_no_if_valid", if_valid[0], 1'b0);
      adv();
    end
    rq[0].if_req = 1'b1; rq[0].if_addr = 32'd4;
    eval(); adv(); eval(); adv(); eval();
    check("rst_after_fetch", {if_valid[0], if_rdata[0]}, {1'b1, 32'h8C01_0000});
    adv();
    idle_cycles(1);

    // Randomized traffic on both instances against the model.
    for (int n = 0; n < 2000; n++) begin
      rq[0] = rand_req();
      rq[1] = rand_req();
      eval();
      adv();
    end
    idle_cycles(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
